// File: rtl/gac_regfile_nrd.sv
`default_nettype none
// ============================================================================
// Module : gac_regfile_nrd
// Desc   : DEPTH x WIDTH register file, one write port, NRD read ports with
//          optional registered read, write-to-read bypass and zero entry.
// Rev    : 1.0  initial release
// ============================================================================
module gac_regfile_nrd #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int RD_REG   = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rvalid
);

    // One extra bit so DEPTH == 2**AW is representable in the range check.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam bit          c_ZERO  = (ZERO_REG != 0);
    localparam bit          c_BYP   = (BYPASS != 0);

    logic             w_wlegal;
    logic             w_wv;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign w_wlegal = ({1'b0, waddr} < c_DEPTH) && !(c_ZERO && (waddr == '0));
    assign w_wv     = we && w_wlegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (w_wv) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (waddr == AW'(e)) begin
                    mem_q[e] <= wdata;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]    w_ra;
        logic             w_rlegal;
        logic             w_hit;
        logic [WIDTH-1:0] w_src;

        assign w_ra     = raddr[p*AW +: AW];
        assign w_rlegal = ({1'b0, w_ra} < c_DEPTH) && !(c_ZERO && (w_ra == '0));
        assign w_hit    = c_BYP && w_wv && (waddr == w_ra);

        always_comb begin
            w_src = '0;
            if (w_rlegal) begin
                if (w_hit) begin
                    w_src = wdata;
                end else begin
                    for (int e = 0; e < DEPTH; e++) begin
                        if (w_ra == AW'(e)) begin
                            w_src = mem_q[e];
                        end
                    end
                end
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic [WIDTH-1:0] rdata_d;
            logic             rvalid_q;

            always_comb begin
                rdata_d = re[p] ? w_src : rdata_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= re[p];
                end
            end

            assign rdata[p*WIDTH +: WIDTH] = rdata_q;
            assign rvalid[p]               = rvalid_q;
        end else begin : g_comb
            // Read enable has no meaning for a combinational port.
            logic w_unused_re;
            assign w_unused_re             = re[p];
            assign rdata[p*WIDTH +: WIDTH] = w_src;
            assign rvalid[p]               = rst_n;
        end
    end

endmodule
`default_nettype wire
